// File: rtl/flash_erase_ctrl_if.sv
// Request/SPI bundle for flash_erase_ctrl.
// Handshake: start is a one-cycle request, honoured only on a cycle where the
// controller is idle (busy=0 and not in its done cycle); mode/addr are
// captured on that same edge. busy rises the next cycle and falls together
// with the one-cycle done pulse. There is no back-pressure on done.
// state_dbg mirrors the controller FSM encoding for checkers.
interface flash_erase_ctrl_if;
  logic        start;
  logic        mode;
  logic [23:0] addr;
  logic        busy;
  logic        done;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [2:0]  state_dbg;

  modport master (output start, mode, addr, miso,
                  input  busy, done, sck, cs_n, mosi, state_dbg);
  modport slave  (input  start, mode, addr, miso,
                  output busy, done, sck, cs_n, mosi, state_dbg);
endinterface

// File: rtl/flash_erase_ctrl.sv
// SPI flash erase sequencer: WREN, then Sector Erase (D8 + addr) or Bulk
// Erase (C7), SPI mode 0, MSB first. Optional status polling (RDSR until
// WIP clears) is enabled with FLASH_ERASE_STATUS_POLL_EN.
// All SPI pins are registered from next-state decode so they never glitch.
module flash_erase_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int CS_GAP   = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  flash_erase_ctrl_if.slave bus
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
  localparam logic [15:0] HALF       = 16'(CLK_DIV);
  localparam logic [15:0] BIT_LAST   = 16'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREN  = 3'd1,
    S_GAP1  = 3'd2,
    S_ERASE = 3'd3,
    S_GAP2  = 3'd4,
`ifdef FLASH_ERASE_STATUS_POLL_EN
    S_POLL  = 3'd5,
    S_GAP3  = 3'd6,
`endif
    S_DONE  = 3'd7
  } state_t;

  // Phase inside one cs_n-low transaction.
  typedef enum logic [1:0] {P_SETUP, P_BITS, P_HOLD} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [15:0] tick, tick_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic        mode_q;
  logic [23:0] addr_q;
  logic        xfer_n;
  logic [7:0]  byte_n;
  logic        busy_q, done_q, sck_q, cs_n_q, mosi_q;
  logic        busy_d, done_d, sck_d, cs_n_d, mosi_d;

`ifdef FLASH_ERASE_STATUS_POLL_EN
  logic [7:0]  status;
  logic        unused_status_msb;
  assign unused_status_msb = status[7];
`else
  logic        unused_miso;
  assign unused_miso = bus.miso;
`endif

  function automatic logic is_xfer(state_t s);
    is_xfer = (s == S_WREN) || (s == S_ERASE)
`ifdef FLASH_ERASE_STATUS_POLL_EN
              || (s == S_POLL)
`endif
              ;
  endfunction

  // Index of the final byte of the transaction issued in state s.
  function automatic logic [1:0] last_byte_of(state_t s, logic m);
    logic [1:0] v;
    v = 2'd0;
    if (s == S_ERASE && !m) v = 2'd3;
`ifdef FLASH_ERASE_STATUS_POLL_EN
    if (s == S_POLL) v = 2'd1;
`endif
    return v;
  endfunction

  // Byte b of the transaction issued in state s.
  function automatic logic [7:0] cmd_byte(state_t s, logic m, logic [23:0] a, logic [1:0] b);
    logic [7:0] v;
    v = 8'h06;
    if (s == S_ERASE) begin
      if (m) v = 8'hC7;
      else begin
        case (b)
          2'd0:    v = 8'hD8;
          2'd1:    v = a[23:16];
          2'd2:    v = a[15:8];
          default: v = a[7:0];
        endcase
      end
    end
`ifdef FLASH_ERASE_STATUS_POLL_EN
    else if (s == S_POLL) v = (b == 2'd0) ? 8'h05 : 8'h00;
`endif
    return v;
  endfunction

  // Next-state, counter update and next-output decode.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    tick_n     = tick;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n    = S_WREN;
          phase_n    = P_SETUP;
          tick_n     = '0;
          bit_cnt_n  = 3'd7;
          byte_cnt_n = 2'd0;
        end
      end
      S_GAP1: begin
        if (tick == GAP_LAST) begin
          state_n = S_ERASE;
          tick_n  = '0;
        end else tick_n = tick + 16'd1;
      end
      S_GAP2: begin
        if (tick == GAP_LAST) begin
`ifdef FLASH_ERASE_STATUS_POLL_EN
          state_n = S_POLL;
`else
          state_n = S_DONE;
`endif
          tick_n  = '0;
        end else tick_n = tick + 16'd1;
      end
`ifdef FLASH_ERASE_STATUS_POLL_EN
      S_GAP3: begin
        if (tick == GAP_LAST) begin
          state_n = status[0] ? S_POLL : S_DONE;
          tick_n  = '0;
        end else tick_n = tick + 16'd1;
      end
`endif
      S_DONE: state_n = S_IDLE;
      default: begin
        // Transaction states: setup, shift bytes, hold, then the cs_n gap.
        case (phase)
          P_SETUP: begin
            if (tick == SETUP_LAST) begin
              phase_n = P_BITS;
              tick_n  = '0;
            end else tick_n = tick + 16'd1;
          end
          P_BITS: begin
            if (tick == BIT_LAST) begin
              tick_n = '0;
              if (bit_cnt != 3'd0) bit_cnt_n = bit_cnt - 3'd1;
              else if (byte_cnt != last_byte_of(state, mode_q)) begin
                byte_cnt_n = byte_cnt + 2'd1;
                bit_cnt_n  = 3'd7;
              end else phase_n = P_HOLD;
            end else tick_n = tick + 16'd1;
          end
          default: begin
            if (tick == HOLD_LAST) begin
              tick_n     = '0;
              phase_n    = P_SETUP;
              bit_cnt_n  = 3'd7;
              byte_cnt_n = 2'd0;
              if (state == S_WREN) state_n = S_GAP1;
`ifdef FLASH_ERASE_STATUS_POLL_EN
              else if (state == S_POLL) state_n = S_GAP3;
`endif
              else state_n = S_GAP2;
            end else tick_n = tick + 16'd1;
          end
        endcase
      end
    endcase

    xfer_n = is_xfer(state_n);
    byte_n = cmd_byte(state_n, mode_q, addr_q, byte_cnt_n);
    busy_d = (state_n != S_IDLE) && (state_n != S_DONE);
    done_d = (state_n == S_DONE);
    cs_n_d = !xfer_n;
    sck_d  = xfer_n && (phase_n == P_BITS) && (tick_n >= HALF);
    mosi_d = xfer_n && (phase_n == P_BITS) && byte_n[bit_cnt_n];
  end

  // State, counters, request capture and registered pins.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      phase    <= P_SETUP;
      tick     <= '0;
      bit_cnt  <= 3'd7;
      byte_cnt <= 2'd0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      tick     <= tick_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      if (state == S_IDLE && bus.start) begin
        mode_q <= bus.mode;
        addr_q <= bus.addr;
      end
      busy_q   <= busy_d;
      done_q   <= done_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
    end
  end

`ifdef FLASH_ERASE_STATUS_POLL_EN
  // Shift in the RDSR reply on the edge where sck rises in the second byte.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) status <= '0;
    else if (state == S_POLL && phase == P_BITS && byte_cnt == 2'd1 &&
             tick == HALF - 16'd1)
      status <= {status[6:0], bus.miso};
  end
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sck       = sck_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Directed bench for flash_erase_ctrl: one instance at CLK_DIV=2 and one at
// CLK_DIV=1, a pin monitor that rebuilds transactions, and an RDSR reply model.
module tb_flash_erase_ctrl;
  localparam int CS_SETUP = 1;
  localparam int CS_HOLD  = 1;
  localparam int CS_GAP   = 5;
`ifdef FLASH_ERASE_STATUS_POLL_EN
  localparam int NPOLL = 1;
`else
  localparam int NPOLL = 0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;

  flash_erase_ctrl_if bus0 ();
  flash_erase_ctrl_if bus1 ();

  flash_erase_ctrl #(.CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP))
    dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0));
  flash_erase_ctrl #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP))
    dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1));

  // ---------------- clock / watchdog ----------------
  always #10 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitored pins (selected instance) ----------------
  logic mon_sck, mon_cs_n, mon_mosi, mon_busy, mon_done, mdl_miso;
  assign mon_sck  = (sel != 0) ? bus1.sck  : bus0.sck;
  assign mon_cs_n = (sel != 0) ? bus1.cs_n : bus0.cs_n;
  assign mon_mosi = (sel != 0) ? bus1.mosi : bus0.mosi;
  assign mon_busy = (sel != 0) ? bus1.busy : bus0.busy;
  assign mon_done = (sel != 0) ? bus1.done : bus0.done;
  assign bus0.miso = mdl_miso;
  assign bus1.miso = mdl_miso;

  // ---------------- flash RDSR reply model ----------------
  logic [7:0] reply_q[$];
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_reply = 8'h00;
  logic       m_prev_sck = 1'b0;
  int         m_rises = 0;
  initial mdl_miso = 1'b0;

  always @(mon_sck or mon_cs_n) begin
    if (mon_cs_n) begin
      m_rises  = 0;
      m_cmd    = 8'h00;
      mdl_miso = 1'b0;
    end else if (mon_sck && !m_prev_sck) begin
      if (m_rises < 8) m_cmd = {m_cmd[6:0], mon_mosi};
      m_rises++;
    end else if (!mon_sck && m_prev_sck) begin
      if (m_rises == 8 && m_cmd == 8'h05)
        m_reply = (reply_q.size() > 0) ? reply_q.pop_front() : 8'h00;
      if (m_cmd == 8'h05 && m_rises >= 8 && m_rises < 16)
        mdl_miso = m_reply[3'(15 - m_rises)];
    end
    m_prev_sck = mon_sck;
  end

  // ---------------- pin monitor ----------------
  typedef struct {
    int          len;
    int          nbits;
    logic [31:0] data;
    int          first_rise;
    int          pmin;
    int          pmax;
  } txn_t;

  txn_t txn_q[$];
  int   gap_q[$];
  txn_t cur;
  logic prev_cs_n = 1'b1;
  logic prev_sck  = 1'b0;
  int   hi_cnt = 0, hi_track = 0, cyc = 0, last_rise = 0;
  int   done_cnt = 0, rise_cnt = 0, mosi_viol = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (mon_cs_n && mon_mosi) mosi_viol++;
    if (mon_done) done_cnt++;
    if (!mon_cs_n) begin
      if (prev_cs_n) begin
        if (hi_track != 0) gap_q.push_back(hi_cnt);
        hi_track = 0;
        cur.len = 0; cur.nbits = 0; cur.data = '0;
        cur.first_rise = -1; cur.pmin = 1000; cur.pmax = 0;
      end
      cur.len++;
      if (mon_sck && !prev_sck) begin
        if (cur.nbits > 0) begin
          if (cyc - last_rise < cur.pmin) cur.pmin = cyc - last_rise;
          if (cyc - last_rise > cur.pmax) cur.pmax = cyc - last_rise;
        end
        if (cur.first_rise < 0) cur.first_rise = cur.len;
        cur.data = {cur.data[30:0], mon_mosi};
        cur.nbits++;
        rise_cnt++;
        last_rise = cyc;
      end
    end else begin
      if (!prev_cs_n) begin
        txn_q.push_back(cur);
        hi_track = 1;
        hi_cnt   = 0;
      end
      if (hi_track != 0) hi_cnt++;
    end
    if (!mon_busy) hi_track = 0;
    prev_cs_n = mon_cs_n;
    prev_sck  = mon_sck;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int s, input logic st, input logic m, input logic [23:0] a);
    if (s == 0) begin bus0.start = st; bus0.mode = m; bus0.addr = a; end
    else        begin bus1.start = st; bus1.mode = m; bus1.addr = a; end
  endtask

  // Issue one request and score the whole sequence. Returns at an idle negedge.
  task automatic run_seq(input int s, input int cdiv, input logic m, input logic [23:0] a,
                         input int npoll, input int mid_at, input int start_in_done);
    logic [63:0] exp_q[$];
    logic [63:0] e;
    txn_t        t;
    int          exp_lat, exp_bits, lat, d0, r0, v0, idle_bad, n;
    exp_q.delete();
    exp_q.push_back({16'(CS_SETUP + 16 * cdiv + CS_HOLD), 16'd8, 32'h06});
    if (m) exp_q.push_back({16'(CS_SETUP + 16 * cdiv + CS_HOLD), 16'd8, 32'hC7});
    else   exp_q.push_back({16'(CS_SETUP + 64 * cdiv + CS_HOLD), 16'd32, {8'hD8, a}});
    for (int i = 0; i < npoll; i++)
      exp_q.push_back({16'(CS_SETUP + 32 * cdiv + CS_HOLD), 16'd16, 32'h0500});
    exp_lat = 1; exp_bits = 0;
    foreach (exp_q[i]) begin
      exp_lat  += int'(exp_q[i][63:48]) + CS_GAP;
      exp_bits += int'(exp_q[i][47:32]);
    end

    sel = s;
    @(negedge sys_clk);
    txn_q.delete(); gap_q.delete();
    d0 = done_cnt; r0 = rise_cnt; v0 = mosi_viol;
    set_req(s, 1'b1, m, a);
    @(negedge sys_clk);
    set_req(s, 1'b0, m, a);
    check("accept_busy", 32'(mon_busy), 32'd1);
    check("accept_cs_n", 32'(mon_cs_n), 32'd0);

    lat = 1;
    while (!mon_done && lat < 3000) begin
      if (mid_at > 0 && lat == mid_at) set_req(s, 1'b1, 1'b1, 24'h000000);
      else if (mid_at > 0) set_req(s, 1'b0, 1'b1, 24'h000000);
      @(negedge sys_clk);
      lat++;
    end
    check("done_latency", lat, exp_lat);
    check("done_busy_low", 32'(mon_busy), 32'd0);
    if (start_in_done != 0) set_req(s, 1'b1, 1'b1, 24'h000000);
    @(negedge sys_clk);
    set_req(s, 1'b0, 1'b0, 24'h000000);
    check("done_single", 32'(mon_done), 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mon_busy || !mon_cs_n || mon_sck) idle_bad++;
      @(negedge sys_clk);
    end
    check("idle_after_done", idle_bad, 0);

    n = exp_q.size();
    check("txn_count", txn_q.size(), n);
    while (exp_q.size() > 0 && txn_q.size() > 0) begin
      e = exp_q.pop_front();
      t = txn_q.pop_front();
      check("cs_low_len", t.len, 32'(e[63:48]));
      check("bit_count", t.nbits, 32'(e[47:32]));
      check("mosi_bits", t.data, e[31:0]);
      check("first_rise", t.first_rise, CS_SETUP + cdiv + 1);
      check("sck_period_min", t.pmin, 2 * cdiv);
      check("sck_period_max", t.pmax, 2 * cdiv);
    end
    check("gap_count", gap_q.size(), n - 1);
    while (gap_q.size() > 0) check("gap_len", gap_q.pop_front(), CS_GAP);
    check("sck_rises", rise_cnt - r0, exp_bits);
    check("done_pulses", done_cnt - d0, 1);
    check("mosi_idle_zero", mosi_viol - v0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, d0;
    set_req(0, 1'b0, 1'b0, 24'h0);
    set_req(1, 1'b0, 1'b0, 24'h0);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_sck", 32'(bus0.sck), 32'd0);
    check("rst_cs_n", 32'(bus0.cs_n), 32'd1);
    check("rst_mosi", 32'(bus0.mosi), 32'd0);
    check("rst_state", 32'(bus0.state_dbg), 32'd0);
    check("rst_cs_n_div1", 32'(bus1.cs_n), 32'd1);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Bulk erase, with a start pulse in the done cycle that must be ignored.
    run_seq(0, 2, 1'b1, 24'h000000, NPOLL, 0, 1);
    // Sector erase.
    run_seq(0, 2, 1'b0, 24'h1A2B3C, NPOLL, 0, 0);
    // Start with mode=1/addr=0 mid-ERASE must not disturb the sequence.
    run_seq(0, 2, 1'b0, 24'h1A2B3C, NPOLL, 60, 0);

    // Reset during ERASE byte 2 aborts without a done pulse.
    sel = 0;
    d0 = done_cnt;
    @(negedge sys_clk);
    set_req(0, 1'b1, 1'b0, 24'h123456);
    @(negedge sys_clk);
    set_req(0, 1'b0, 1'b0, 24'h123456);
    lat = 1;
    while (lat < 80) begin @(negedge sys_clk); lat++; end
    check("pre_rst_cs_n", 32'(bus0.cs_n), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("abort_cs_n", 32'(bus0.cs_n), 32'd1);
    check("abort_sck", 32'(bus0.sck), 32'd0);
    check("abort_mosi", 32'(bus0.mosi), 32'd0);
    check("abort_busy", 32'(bus0.busy), 32'd0);
    check("abort_done", 32'(bus0.done), 32'd0);
    check("abort_state", 32'(bus0.state_dbg), 32'd0);
    sys_rst = 1'b0;
    repeat (250) @(negedge sys_clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_seq(0, 2, 1'b1, 24'h000000, NPOLL, 0, 0);

`ifdef FLASH_ERASE_STATUS_POLL_EN
    // WIP stays set for two polls, clears on the third.
    reply_q.delete();
    reply_q.push_back(8'h03);
    reply_q.push_back(8'h03);
    reply_q.push_back(8'h00);
    run_seq(0, 2, 1'b1, 24'h000000, 3, 0, 0);
    check("poll_replies_used", reply_q.size(), 0);
`endif

    // CLK_DIV=1 instance: bulk and sector erase.
    run_seq(1, 1, 1'b1, 24'h000000, NPOLL, 0, 0);
    run_seq(1, 1, 1'b0, 24'hFF00A5, NPOLL, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_erase_ctrl.md
Name: flash_erase_ctrl

Overview:
- Parametrised successor to the single-purpose bulk-erase controller: one start pulse issues WREN (0x06), then either Sector Erase (0xD8 + 24-bit address) or Bulk Erase (0xC7) to an M25P16-class SPI flash.
- SPI mode 0, MSB first, SCK divider and CS timing are parametrised.
- Sits between a key/command source and the flash pins; reports busy/done to the requester.

Parameters:
- CLK_DIV, 2, sys_clk cycles per SCK half-period (>=1); SCK period = 2*CLK_DIV cycles.
- CS_SETUP, 1, cycles from cs_n falling to the first SCK rising-edge phase start (>=1).
- CS_HOLD, 1, cycles from the last SCK falling edge to cs_n rising (>=1).
- CS_GAP, 5, minimum cycles cs_n stays high between transactions (>=1; 5 cycles = 100 ns at 50 MHz, meets tSHSL).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only while busy=0.
- mode  in  1  0 = sector erase, 1 = bulk erase; latched with start.
- addr  in  24  sector-erase address; latched with start; ignored for bulk erase.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence completes.
- sck  out  1  SPI clock; idles low.
- cs_n  out  1  SPI chip select, active-low.
- mosi  out  1  SPI data to flash.
- miso  in  1  SPI data from flash; used only with STATUS_POLL_EN.

Behaviour:
- Reset values (and the value on the cycle after sys_rst is seen high, from any state): busy=0, done=0, sck=0, cs_n=1, mosi=0, FSM=IDLE. Reset mid-transaction aborts the sequence immediately with no done pulse.
- FSM: IDLE -> WREN -> GAP1 -> ERASE -> GAP2 -> [POLL -> GAP3 loop] -> DONE -> IDLE.
- IDLE: start=1 latches mode/addr. Next cycle: busy=1, WREN begins with cs_n=0.
- Transaction timing (every command):
  - cs_n low for CS_SETUP cycles.
  - Then each bit takes 2*CLK_DIV cycles: mosi updates at the start of the low phase, sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles. The flash samples on the rising edge.
  - After the last bit's falling edge: CS_HOLD cycles, then cs_n=1.
  - cs_n-low length = CS_SETUP + 16*CLK_DIV*nbytes + CS_HOLD.
- WREN: 1 byte, 0x06.
- GAP states: cs_n=1, sck=0, mosi=0 for exactly CS_GAP cycles.
- ERASE:
  - mode=0: 4 bytes, 0xD8, addr[23:16], addr[15:8], addr[7:0].
  - mode=1: 1 byte, 0xC7.
- DONE: done=1 for one cycle and busy=0 in the same cycle; FSM returns to IDLE. A start in the DONE cycle is ignored.
- start while busy=1 is ignored; mode/addr changes while busy have no effect.
- Byte counter 0..3 and bit counter 7..0. The divider counter resets at each transaction start so that SCK phase is deterministic.
- mosi is 0 whenever cs_n=1.

Optional Feature:
- Macro: FLASH_ERASE_STATUS_POLL_EN.
- Defined:
  - After GAP2, POLL issues RDSR (0x05), keeps cs_n low, and clocks 8 more bits with mosi=0.
  - miso is sampled on each sck rising edge, MSB first, into a status register.
  - After CS_HOLD and a CS_GAP gap, if status[0] (WIP)=1 the FSM repeats POLL; if 0 it goes to DONE.
  - POLL cs_n-low length = CS_SETUP + 32*CLK_DIV + CS_HOLD.
- Undefined: no POLL states; GAP2 goes straight to DONE, miso is ignored, and done means the erase command was issued, not completed.

Test Plan (CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, CS_GAP=5):
- Bulk erase: reset, then start=1 with mode=1 -> WREN cs_n low 34 cycles with bits 00000110; cs_n high 5 cycles; BE cs_n low 34 cycles with bits 11000111; 5-cycle gap; then done pulses once and busy falls (no poll).
- Sector erase: mode=0, addr=0x1A2B3C -> ERASE cs_n low 130 cycles; mosi bytes D8 1A 2B 3C sampled on rising edges; exactly 40 sck rising edges across both transactions.
- Ignore start: pulse start again mid-ERASE with mode=1 and addr=0 -> sequence unchanged; exactly one done pulse.
- Reset mid-transaction: assert sys_rst during the ERASE byte 2 -> next cycle cs_n=1, sck=0, mosi=0, busy=0; no done; a fresh start then runs the full sequence from WREN.
- Poll (FLASH_ERASE_STATUS_POLL_EN, flash model replies 0x03, 0x03, then 0x00) -> three RDSR transactions of 66 cycles each; done pulses after the third gap.
- CLK_DIV=1 sweep: sck period 2 cycles; WREN cs_n low 18 cycles; m25p16 model accepts WREN and BE without a timing violation.
